// File: rtl/axis_fifo_sync.sv
// Synchronous first-word-fall-through AXI-Stream FIFO.
// Power-of-two depth, so the pointers wrap naturally and the occupancy is tracked in count.
module axis_fifo_sync #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    count     = count_q;
    out_data  = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; a write during reset is harmless since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule
